collision_event_unit: RTL and testbench
=======================================

Name: collision_event_unit

Overview:
Parametrised successor to the ad hoc collision handling in the game top level (one-cycle delay registers for heal/hit, hard-wired collision background colours).
- Takes N raw level-type collision channels from the collision detector.
- Produces clean one-shot event pulses with a per-channel cooldown counted in frames, plus a priority-arbitrated event id.
- Drives a timed background-colour flash state machine that feeds the display logic.

Parameters:
CHANNELS, 4, number of collision channels (1..8); index 0 is highest priority.
COOLDOWN_FRAMES, 30, frames a channel ignores new edges after firing; 0 disables cooldown.
FLASH_FRAMES, 8, frames the background flash lasts; 0 disables flash.
CNT_W, 6, width of cooldown/flash counters; must hold max(COOLDOWN_FRAMES, FLASH_FRAMES); elaboration error otherwise.
IDLE_COLOUR, 6'b00_11_00, RRGGBB background when no flash is active.
PALETTE, {CHANNELS{6'b11_00_00}}, 6 bits per channel; the channel i colour is PALETTE[6i+5:6i].

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
frame_end  input  1  one-cycle pulse per frame from the sync generator
coll_raw  input  CHANNELS  raw collision levels, bit i = channel i
chan_enable  input  CHANNELS  per-channel event enable
event_pulse  output  CHANNELS  one-cycle pulse per accepted event
event_valid  output  1  OR of event_pulse
event_id  output  3  index of the lowest-numbered pulsing channel; 0 when none
cooldown_active  output  CHANNELS  bit i high while channel i cooldown count is nonzero
flash_active  output  1  high in FLASH state
bg_colour  output  6  RRGGBB background colour for the display logic

Behaviour:
Reset:
- All outputs, counters and edge registers go to 0.
- bg_colour = IDLE_COLOUR; FSM state = IDLE.
- Reset applies immediately (asynchronous) and also aborts any flash or cooldown in progress.

Per channel i, every clk:
- prev_i <= coll_raw[i]; edge_i = coll_raw[i] & ~prev_i.
- prev_i always tracks the input, including while disabled. Re-enabling a channel while its input is held high therefore does not fire.
- accept_i = edge_i & chan_enable[i] & (cool_i == 0).
- event_pulse[i] <= accept_i. Latency is 1 cycle from the rising input edge.
- Edges arriving during cooldown are dropped, not queued.

Cooldown counter cool_i:
- On accept_i, cool_i loads COOLDOWN_FRAMES.
- Otherwise, on frame_end with cool_i != 0, cool_i decrements.
- If load and frame_end coincide, load wins (no decrement that cycle).
- Deasserting chan_enable does not stop or clear the counter.
- cooldown_active[i] = (cool_i != 0), combinational from the register.

Arbitration:
- event_valid and event_id are registered together with event_pulse.
- event_id = lowest index set in the accept vector.
- Simultaneous accepts all pulse; only the id is arbitrated.

Flash FSM, states IDLE and FLASH, with registers flash_cnt and flash_ch:
- IDLE -> FLASH: when any accept_i and FLASH_FRAMES != 0. Load flash_cnt = FLASH_FRAMES and flash_ch = winning index. bg_colour <= PALETTE[flash_ch] on the next cycle, the same cycle as event_pulse.
- In FLASH, a new accept with winner index <= flash_ch reloads the counter and colour (retrigger). A new accept with winner index > flash_ch is ignored by the FSM, but its event_pulse still fires.
- In FLASH, each frame_end decrements flash_cnt. A frame_end that takes the count 1 -> 0 returns the FSM to IDLE, with bg_colour = IDLE_COLOUR on the following cycle.
- A reload on the same cycle as frame_end wins over the decrement.
- flash_active = (state == FLASH).

Width rules:
- Counters are unsigned CNT_W and never wrap below 0.
- When CHANNELS < 8, the upper event_id bits are 0.

Decomposition:
Shared game package holds:
- colour width constant (6)
- default IDLE_COLOUR
- named palette constants (RED 6'b11_00_00, BLUE 6'b00_00_11, MAGENTA 6'b11_00_11)
- FSM state typedef (IDLE/FLASH)

Sub-module cooldown_channel (edge register, enable gating, cooldown counter; outputs accept and cooldown_active) is instantiated CHANNELS times via generate. The priority encoder and flash FSM stay in the parent.

Test Plan:
- Reset held, then released with coll_raw=4'b0000 -> all outputs 0, bg_colour=6'b001100, flash_active=0.
- Channel 1 rises and stays high for 100 cycles, chan_enable=4'b1111 -> exactly one event_pulse[1] 1 cycle after the edge; event_id=1; bg_colour=6'b110000 for 8 frame_end pulses, then 6'b001100; cooldown_active[1] clears after 30 frame_end pulses.
- Channel 2 toggles once per frame -> pulses at frame 0 and again only after cool_2 reaches 0 (30 frames). No pulses in between, and no queued event on expiry.
- Channels 0 and 3 rise in the same cycle -> event_pulse=4'b1001, event_id=0, bg_colour=PALETTE[0]. Then channel 3 fires alone while the flash is active -> pulse only, colour unchanged.
- chan_enable[0]=0 while coll_raw[0] rises, then enable asserted with the level still high -> no event. The next genuine rising edge fires.
- Accept coincident with frame_end while flash_cnt=1 -> counter reloads to 8 and the FSM stays in FLASH. Asserting reset mid-flash -> bg_colour=IDLE_COLOUR immediately.

Source files
------------

// File: rtl/collision_event_unit_pkg.sv
// Shared game constants for the collision event path: colour width,
// default background, named palette entries and the flash FSM encoding.
package collision_event_unit_pkg;

  localparam int unsigned COLOUR_W = 6;

  localparam logic [COLOUR_W-1:0] IDLE_COLOUR_DEF = 6'b00_11_00;

  localparam logic [COLOUR_W-1:0] COLOUR_RED     = 6'b11_00_00;
  localparam logic [COLOUR_W-1:0] COLOUR_BLUE    = 6'b00_00_11;
  localparam logic [COLOUR_W-1:0] COLOUR_MAGENTA = 6'b11_00_11;

  // Flash FSM keeps the legacy one-bit encoding.
  typedef logic [0:0] flash_state_t;
  localparam flash_state_t ST_IDLE  = 1'b0;
  localparam flash_state_t ST_FLASH = 1'b1;

endpackage

// File: rtl/collision_event_unit_cooldown_channel.sv
// One collision channel: rising-edge detect, enable gating and a
// frame-counted cooldown that blocks new edges after each accepted event.
module cooldown_channel #(
  parameter int unsigned COOLDOWN_FRAMES = 30,
  parameter int unsigned CNT_W           = 6
) (
  input  logic clk,
  input  logic reset,
  input  logic frame_end,
  input  logic coll_raw,
  input  logic chan_enable,
  output logic accept,
  output logic cooldown_active
);

  localparam logic [CNT_W-1:0] COOL_LOAD = CNT_W'(COOLDOWN_FRAMES);

  logic             prev;
  logic             rise;
  logic [CNT_W-1:0] cool;

  // prev follows the input even while disabled, so enabling onto a held
  // level never produces an event.
  assign rise            = coll_raw & ~prev;
  assign accept          = rise & chan_enable & (cool == '0);
  assign cooldown_active = (cool != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev <= 1'b0;
      cool <= '0;
    end else begin
      prev <= coll_raw;
      if (accept) begin
        cool <= COOL_LOAD;
      end else if (frame_end && (cool != '0)) begin
        cool <= cool - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/collision_event_unit.sv
// Collision event unit: per-channel one-shot events with cooldown, a
// priority-arbitrated event id and a timed background-colour flash.
module collision_event_unit
  import collision_event_unit_pkg::*;
#(
  parameter int unsigned                  CHANNELS        = 4,
  parameter int unsigned                  COOLDOWN_FRAMES = 30,
  parameter int unsigned                  FLASH_FRAMES    = 8,
  parameter int unsigned                  CNT_W           = 6,
  parameter logic [COLOUR_W-1:0]          IDLE_COLOUR     = IDLE_COLOUR_DEF,
  parameter logic [COLOUR_W*CHANNELS-1:0] PALETTE         = {CHANNELS{COLOUR_RED}}
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                frame_end,
  input  logic [CHANNELS-1:0] coll_raw,
  input  logic [CHANNELS-1:0] chan_enable,
  output logic [CHANNELS-1:0] event_pulse,
  output logic                event_valid,
  output logic [2:0]          event_id,
  output logic [CHANNELS-1:0] cooldown_active,
  output logic                flash_active,
  output logic [COLOUR_W-1:0] bg_colour
);

  if ((CHANNELS < 1) || (CHANNELS > 8)) begin : g_bad_channels
    $error("collision_event_unit: CHANNELS must be in 1..8");
  end
  if ((COOLDOWN_FRAMES >= (1 << CNT_W)) || (FLASH_FRAMES >= (1 << CNT_W))) begin : g_bad_cnt_w
    $error("collision_event_unit: CNT_W too narrow for COOLDOWN_FRAMES/FLASH_FRAMES");
  end

  localparam logic [CNT_W-1:0] FLASH_LOAD = CNT_W'(FLASH_FRAMES);
  localparam logic             FLASH_EN   = (FLASH_FRAMES != 0);

  logic [CHANNELS-1:0] accept;
  logic                any_accept;
  logic                found;
  logic [2:0]          win_idx;
  logic [COLOUR_W-1:0] win_colour;
  logic                take_flash;

  flash_state_t        state;
  logic [CNT_W-1:0]    flash_cnt;
  logic [2:0]          flash_ch;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    cooldown_channel #(
      .COOLDOWN_FRAMES (COOLDOWN_FRAMES),
      .CNT_W           (CNT_W)
    ) u_chan (
      .clk             (clk),
      .reset           (reset),
      .frame_end       (frame_end),
      .coll_raw        (coll_raw[i]),
      .chan_enable     (chan_enable[i]),
      .accept          (accept[i]),
      .cooldown_active (cooldown_active[i])
    );
  end

  always_comb begin
    found      = 1'b0;
    win_idx    = '0;
    win_colour = IDLE_COLOUR;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (accept[i] && !found) begin
        found      = 1'b1;
        win_idx    = 3'(i);
        win_colour = PALETTE[COLOUR_W*i +: COLOUR_W];
      end
    end
  end

  assign any_accept = |accept;

  // A lower-or-equal index retriggers the flash; a less important channel
  // still pulses but leaves the running flash alone.
  assign take_flash = any_accept && FLASH_EN &&
                      ((state == ST_IDLE) || (win_idx <= flash_ch));

  assign flash_active = (state == ST_FLASH);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      event_pulse <= '0;
      event_valid <= 1'b0;
      event_id    <= '0;
    end else begin
      event_pulse <= accept;
      event_valid <= any_accept;
      event_id    <= win_idx;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      flash_cnt <= '0;
      flash_ch  <= '0;
      bg_colour <= IDLE_COLOUR;
    end else if (take_flash) begin
      state     <= ST_FLASH;
      flash_cnt <= FLASH_LOAD;
      flash_ch  <= win_idx;
      bg_colour <= win_colour;
    end else if ((state == ST_FLASH) && frame_end) begin
      if (flash_cnt <= CNT_W'(1)) begin
        state     <= ST_IDLE;
        flash_cnt <= '0;
        bg_colour <= IDLE_COLOUR;
      end else begin
        flash_cnt <= flash_cnt - CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_collision_event_unit.sv
// Self-checking bench for collision_event_unit: directed scenarios followed
// by a randomized run, all checked against a frame-level reference model.
module tb_collision_event_unit;
  import collision_event_unit_pkg::*;

  localparam int CH    = 4;
  localparam int COOL  = 30;
  localparam int FL    = 8;
  localparam int PER   = 4;
  localparam logic [23:0] PAL = {6'b11_11_00, COLOUR_BLUE, COLOUR_RED, COLOUR_MAGENTA};
  localparam logic [5:0]  IDLE_C = 6'b00_11_00;

  logic          clk = 1'b0;
  logic          reset;
  logic          frame_end;
  logic [CH-1:0] coll_raw;
  logic [CH-1:0] chan_enable;
  logic [CH-1:0] event_pulse;
  logic          event_valid;
  logic [2:0]    event_id;
  logic [CH-1:0] cooldown_active;
  logic          flash_active;
  logic [5:0]    bg_colour;

  always #5 clk = ~clk;

  collision_event_unit #(
    .CHANNELS        (CH),
    .COOLDOWN_FRAMES (COOL),
    .FLASH_FRAMES    (FL),
    .CNT_W           (6),
    .IDLE_COLOUR     (IDLE_C),
    .PALETTE         (PAL)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .frame_end       (frame_end),
    .coll_raw        (coll_raw),
    .chan_enable     (chan_enable),
    .event_pulse     (event_pulse),
    .event_valid     (event_valid),
    .event_id        (event_id),
    .cooldown_active (cooldown_active),
    .flash_active    (flash_active),
    .bg_colour       (bg_colour)
  );

  int vectors = 0;
  int miscompares = 0;
  int pcount[CH];

  // Reference model state
  int         m_prev[CH];
  int         m_cool[CH];
  logic [3:0] m_pulse;
  logic       m_valid;
  int         m_id;
  bit         m_flash;
  int         m_fcnt;
  int         m_fch;
  logic [5:0] m_bg;

  function automatic logic [5:0] pal_of(int i);
    logic [23:0] p;
    p = PAL;
    return p[6*i +: 6];
  endfunction

  task automatic cmp(string tag, logic [31:0] got, logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < CH; i++) begin
      m_prev[i] = 0;
      m_cool[i] = 0;
    end
    m_pulse = '0; m_valid = 1'b0; m_id = 0;
    m_flash = 1'b0; m_fcnt = 0; m_fch = 0; m_bg = IDLE_C;
  endtask

  task automatic model_step();
    logic [3:0] acc;
    int win;
    acc = '0;
    win = -1;
    for (int i = 0; i < CH; i++) begin
      if (coll_raw[i] && m_prev[i] == 0 && chan_enable[i] && m_cool[i] == 0) acc[i] = 1'b1;
    end
    for (int i = CH - 1; i >= 0; i--) if (acc[i]) win = i;
    for (int i = 0; i < CH; i++) begin
      m_prev[i] = coll_raw[i] ? 1 : 0;
      if (acc[i]) m_cool[i] = COOL;
      else if (frame_end && m_cool[i] > 0) m_cool[i] = m_cool[i] - 1;
    end
    m_pulse = acc;
    m_valid = (win >= 0);
    m_id    = (win >= 0) ? win : 0;
    if (win >= 0 && FL > 0 && (!m_flash || win <= m_fch)) begin
      m_flash = 1'b1; m_fcnt = FL; m_fch = win; m_bg = pal_of(win);
    end else if (m_flash && frame_end) begin
      m_fcnt = m_fcnt - 1;
      if (m_fcnt == 0) begin
        m_flash = 1'b0; m_bg = IDLE_C;
      end
    end
  endtask

  task automatic check_all(string tag);
    logic [3:0] mc;
    for (int i = 0; i < CH; i++) mc[i] = (m_cool[i] != 0);
    cmp({tag, ".pulse"},    32'(event_pulse),     32'(m_pulse));
    cmp({tag, ".valid"},    32'(event_valid),     32'(m_valid));
    cmp({tag, ".id"},       32'(event_id),        32'(m_id));
    cmp({tag, ".cooldown"}, 32'(cooldown_active), 32'(mc));
    cmp({tag, ".flash"},    32'(flash_active),    32'(m_flash));
    cmp({tag, ".bg"},       32'(bg_colour),       32'(m_bg));
  endtask

  task automatic step(string tag, bit fe);
    frame_end = fe;
    model_step();
    @(posedge clk);
    #1;
    check_all(tag);
    for (int i = 0; i < CH; i++) if (event_pulse[i]) pcount[i]++;
    frame_end = 1'b0;
  endtask

  task automatic frame_once(string tag);
    for (int c = 0; c < PER; c++) step(tag, c == PER - 1);
  endtask

  task automatic settle(int nf);
    coll_raw = '0;
    for (int f = 0; f < nf; f++) frame_once("settle");
  endtask

  task automatic do_reset();
    reset = 1'b1;
    frame_end = 1'b0;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    check_all("reset");
    reset = 1'b0;
  endtask

  initial begin
    int base;
    reset = 1'b1;
    frame_end = 1'b0;
    coll_raw = '0;
    chan_enable = '1;
    for (int i = 0; i < CH; i++) pcount[i] = 0;
    #2;
    do_reset();

    // Idle after reset release
    step("idle", 1'b0);
    cmp("idle.bg_const", 32'(bg_colour), 32'(6'b00_11_00));
    cmp("idle.pulse_const", 32'(event_pulse), 32'd0);
    cmp("idle.flash_const", 32'(flash_active), 32'd0);

    // Channel 1 held high: one pulse, 8-frame flash, 30-frame cooldown
    coll_raw = 4'b0010;
    base = pcount[1];
    step("ch1.rise", 1'b0);
    cmp("ch1.pulse_const", 32'(event_pulse), 32'(4'b0010));
    cmp("ch1.id_const", 32'(event_id), 32'd1);
    cmp("ch1.bg_const", 32'(bg_colour), 32'(6'b11_00_00));
    for (int f = 0; f < FL; f++) frame_once("ch1.flash");
    cmp("ch1.bg_after_flash", 32'(bg_colour), 32'(IDLE_C));
    for (int f = FL; f < COOL - 1; f++) frame_once("ch1.cool");
    cmp("ch1.cool_still", 32'(cooldown_active[1]), 32'd1);
    frame_once("ch1.cool_end");
    cmp("ch1.cool_clear", 32'(cooldown_active[1]), 32'd0);
    for (int f = 0; f < 4; f++) frame_once("ch1.hold");
    cmp("ch1.single_pulse", 32'(pcount[1] - base), 32'd1);

    // Channel 2 toggling once per frame
    settle(2);
    base = pcount[2];
    for (int f = 0; f < 32; f++) begin
      coll_raw[2] = ~coll_raw[2];
      frame_once("ch2.toggle");
      if (f == 29) cmp("ch2.blocked", 32'(pcount[2] - base), 32'd1);
    end
    cmp("ch2.refire", 32'(pcount[2] - base), 32'd2);

    // Simultaneous 0+3, then lower-priority 3 during a channel-0 flash
    settle(COOL + 2);
    coll_raw = 4'b1001;
    step("sim.rise", 1'b0);
    cmp("sim.pulse_const", 32'(event_pulse), 32'(4'b1001));
    cmp("sim.id_const", 32'(event_id), 32'd0);
    cmp("sim.bg_const", 32'(bg_colour), 32'(COLOUR_MAGENTA));
    settle(COOL + 2);
    coll_raw = 4'b0001;
    step("lo.ch0", 1'b0);
    step("lo.ch0", 1'b0);
    coll_raw = 4'b1001;
    step("lo.ch3", 1'b0);
    cmp("lo.pulse_const", 32'(event_pulse), 32'(4'b1000));
    cmp("lo.bg_const", 32'(bg_colour), 32'(COLOUR_MAGENTA));

    // Enable raised onto a held level does not fire; next real edge does
    settle(COOL + 2);
    chan_enable = 4'b1110;
    coll_raw = 4'b0001;
    for (int c = 0; c < 3; c++) step("en.disabled", 1'b0);
    chan_enable = 4'b1111;
    for (int c = 0; c < 3; c++) begin
      step("en.held", 1'b0);
      cmp("en.no_event", 32'(event_pulse[0]), 32'd0);
    end
    coll_raw = 4'b0000;
    step("en.drop", 1'b0);
    coll_raw = 4'b0001;
    step("en.rise", 1'b0);
    cmp("en.fire", 32'(event_pulse), 32'(4'b0001));

    // Retrigger on the frame_end that would end the flash
    settle(COOL + 2);
    coll_raw = 4'b1000;
    step("rt.ch3", 1'b0);
    for (int f = 0; f < FL - 1; f++) frame_once("rt.run");
    coll_raw = 4'b1100;
    step("rt.coincide", 1'b1);
    cmp("rt.flash_stays", 32'(flash_active), 32'd1);
    cmp("rt.bg_blue", 32'(bg_colour), 32'(COLOUR_BLUE));
    for (int f = 0; f < FL - 1; f++) frame_once("rt.run2");
    cmp("rt.flash_full", 32'(flash_active), 32'd1);
    frame_once("rt.end");
    cmp("rt.flash_done", 32'(flash_active), 32'd0);

    // Asynchronous reset during a flash
    settle(COOL + 2);
    coll_raw = 4'b0010;
    step("ar.rise", 1'b0);
    frame_once("ar.run");
    #2;
    reset = 1'b1;
    #1;
    cmp("ar.bg_now", 32'(bg_colour), 32'(IDLE_C));
    cmp("ar.flash_now", 32'(flash_active), 32'd0);
    cmp("ar.cool_now", 32'(cooldown_active), 32'd0);
    coll_raw = '0;
    do_reset();

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < CH; i++) begin
        if ($urandom_range(0, 3) == 0) coll_raw[i] = ~coll_raw[i];
        if ($urandom_range(0, 15) == 0) chan_enable[i] = ~chan_enable[i];
      end
      if ($urandom_range(0, 599) == 0) do_reset();
      else step("rand", $urandom_range(0, 2) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
